// File: rtl/sb_color_event_filter.sv
// rtl/sb_color_event_filter.sv - debounced colour confirmation with a 4-deep event FIFO
module sb_color_event_filter #(
  parameter int SAMPLE_DIV     = 5000000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] color_in,
  output logic [2:0] confirmed,
  output logic       ev_valid,
  output logic [1:0] ev_color,
  input  logic       ev_ready,
  output logic [7:0] ev_count,
  output logic       overflow
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [3:0] S_MAX = 4'(STABLE_SAMPLES);

  typedef enum logic [2:0] {C_NONE, C_RED, C_GRN, C_BLU, C_WHITE} cls_t;
  typedef enum logic {S_BG, S_BLK} state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  cls_t          cls;
  cls_t          cand;
  logic [2:0]    cls_code;
  logic [3:0]    match;
  logic [3:0]    match_nxt;
  logic          confirm;
  logic          is_block;
  logic          push_req;
  state_t        state;

  logic [1:0]    mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    occ;
  logic          full;
  logic          pop;
  logic          accept;

  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    cls      = C_NONE;
    cls_code = 3'b000;
    case (color_in)
      3'b100: begin cls = C_RED;   cls_code = 3'b100; end
      3'b010: begin cls = C_GRN;   cls_code = 3'b010; end
      3'b001: begin cls = C_BLU;   cls_code = 3'b001; end
      3'b111: begin cls = C_WHITE; cls_code = 3'b111; end
      default: begin cls = C_NONE; cls_code = 3'b000; end
    endcase
  end

  // A saturated match on the same candidate must not fire again.
  always_comb begin
    match_nxt = 4'd1;
    if (cls == cand)
      match_nxt = (match == S_MAX) ? S_MAX : match + 4'd1;
  end

  assign confirm  = tick && (match_nxt == S_MAX) && !((cls == cand) && (match == S_MAX));
  assign is_block = (cls == C_RED) || (cls == C_GRN) || (cls == C_BLU);
  assign push_req = confirm && is_block && ((state == S_BG) || (cls_code != confirmed));

  assign ev_valid = (occ != 3'd0);
  assign ev_color = ev_valid ? mem[rd_ptr] : 2'b00;
  assign full     = (occ == 3'd4);
  assign pop      = ev_valid && ev_ready;
  assign accept   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      cand      <= C_NONE;
      match     <= 4'd0;
      state     <= S_BG;
      confirmed <= 3'b000;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      occ       <= 3'd0;
      ev_count  <= 8'd0;
      overflow  <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= 2'b00;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        cand  <= cls;
        match <= match_nxt;
      end
      if (confirm) begin
        confirmed <= cls_code;
        state     <= is_block ? S_BLK : S_BG;
      end
      if (accept) begin
        mem[wr_ptr] <= cls[1:0];
        wr_ptr      <= wr_ptr + 2'd1;
        ev_count    <= ev_count + 8'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, accept} - {2'b00, pop};
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sb_color_event_filter.sv
// tb/tb_sb_color_event_filter.sv - directed and random checks against a queue-based reference model
module tb_sb_color_event_filter;
  localparam int DIV    = 4;
  localparam int STABLE = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] color_in;
  logic [2:0] confirmed;
  logic       ev_valid;
  logic [1:0] ev_color;
  logic       ev_ready;
  logic [7:0] ev_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;

  int         m_k, m_prev, m_run, m_cnt;
  logic [2:0] m_conf;
  bit         m_ovf;
  logic [1:0] q[$];

  sb_color_event_filter #(.SAMPLE_DIV(DIV), .STABLE_SAMPLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .confirmed(confirmed),
    .ev_valid(ev_valid), .ev_color(ev_color), .ev_ready(ev_ready),
    .ev_count(ev_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cls_of(logic [2:0] c);
    case (c)
      3'b100: return 1;
      3'b010: return 2;
      3'b001: return 3;
      3'b111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] code_of(int c);
    case (c)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      4: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_prev = -1; m_run = 0; m_cnt = 0;
    m_conf = 3'b000; m_ovf = 0;
    q.delete();
  endtask

  // One clock: model advances on the posedge, DUT is compared on the negedge.
  task automatic step();
    int c;
    bit pop, full, push;
    logic [2:0] code;
    logic [1:0] ev;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_k++;
      push = 0;
      c = 0;
      full = (q.size() == 4);
      pop  = (q.size() > 0) && ev_ready;
      if (m_k % DIV == 0) begin
        c = cls_of(color_in);
        if (c == m_prev) m_run++;
        else begin m_run = 1; m_prev = c; end
        if (m_run == STABLE) begin
          code = code_of(c);
          if (c >= 1 && c <= 3 && code != m_conf) push = 1;
          m_conf = code;
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!full || pop) begin
          ev = 2'(c);
          q.push_back(ev);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovf = 1;
        end
      end
    end
    @(negedge clk);
    if (ev_valid === 1'b1) valid_cycles++;
    chk("confirmed", 32'(confirmed), 32'(m_conf));
    chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
    chk("ev_color", 32'(ev_color), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("ev_count", 32'(ev_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic hold(logic [2:0] c, int ticks);
    color_in = c;
    repeat (ticks * DIV) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp4 [4];
  logic [1:0] exp5 [4];
  logic [2:0] pal  [8];

  initial begin
    exp4 = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp5 = '{2'b10, 2'b01, 2'b10, 2'b01};
    pal  = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000, 3'b011, 3'b101, 3'b110};
    model_reset();
    rst_n = 1'b0; color_in = 3'b000; ev_ready = 1'b0;
    step();
    step();
    chk("rst_confirmed", 32'(confirmed), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);

    // 1: steady red confirms on the third tick edge
    rst_n = 1'b1; color_in = 3'b100;
    repeat (11) step();
    chk("t1_pre_valid", 32'(ev_valid), 32'd0);
    step();
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_color", 32'(ev_color), 32'd1);
    chk("t1_conf", 32'(confirmed), 32'h4);
    chk("t1_count", 32'(ev_count), 32'd1);
    repeat (4) step();

    // 2: alternating colours never confirm
    do_reset();
    for (int i = 0; i < 20; i++) hold((i % 2) ? 3'b010 : 3'b100, 1);
    chk("t2_conf", 32'(confirmed), 32'd0);
    chk("t2_valid", 32'(ev_valid), 32'd0);

    // 3: R, W, G, B with the consumer always ready
    do_reset();
    ev_ready = 1'b1;
    valid_cycles = 0;
    hold(3'b100, 3); hold(3'b111, 3); hold(3'b010, 3); hold(3'b001, 3);
    chk("t3_pulses", 32'(valid_cycles), 32'd3);
    chk("t3_conf", 32'(confirmed), 32'h1);
    chk("t3_count", 32'(ev_count), 32'd3);

    // 4: five confirmations into a stalled FIFO
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) hold((i % 2) ? 3'b010 : 3'b100, 3);
    chk("t4_count", 32'(ev_count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 32'(ev_color), 32'(exp4[i]));
      step();
    end
    chk("t4_empty", 32'(ev_valid), 32'd0);

    // 5: push coincides with pop while full
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) hold((i % 2) ? 3'b010 : 3'b100, 3);
    color_in = 3'b100;
    repeat (11) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    step();
    chk("t5_count", 32'(ev_count), 32'd5);
    chk("t5_ovf", 32'(overflow), 32'd0);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain", 32'(ev_color), 32'(exp5[i]));
      step();
    end
    chk("t5_empty", 32'(ev_valid), 32'd0);

    // 6: reset with queued events and a partial match
    do_reset();
    ev_ready = 1'b0;
    hold(3'b100, 3); hold(3'b010, 3);
    color_in = 3'b001;
    repeat (2 * DIV) step();
    rst_n = 1'b0;
    step();
    chk("t6_conf", 32'(confirmed), 32'd0);
    chk("t6_valid", 32'(ev_valid), 32'd0);
    chk("t6_color", 32'(ev_color), 32'd0);
    chk("t6_count", 32'(ev_count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (11) step();
    chk("t6_pre_valid", 32'(ev_valid), 32'd0);
    step();
    chk("t6_valid_after", 32'(ev_valid), 32'd1);
    chk("t6_color_after", 32'(ev_color), 32'd3);

    // random colours, hold times, consumer stalls and occasional resets
    do_reset();
    for (int s = 0; s < 300; s++) begin
      color_in = pal[$urandom_range(0, 7)];
      repeat ($urandom_range(4, 24)) begin
        ev_ready = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
        step();
      end
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
